// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU/branch/writeback
// codes and the sequencer state type.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [2:0] BR_NEVER  = 3'd0;
    localparam logic [2:0] BR_EQ     = 3'd1;
    localparam logic [2:0] BR_NE     = 3'd2;
    localparam logic [2:0] BR_LT     = 3'd3;
    localparam logic [2:0] BR_GE     = 3'd4;
    localparam logic [2:0] BR_LTU    = 3'd5;
    localparam logic [2:0] BR_GEU    = 3'd6;
    localparam logic [2:0] BR_ALWAYS = 3'd7;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } state_e;

    // alt selects SUB over ADD and SRA over SRL (instr bit 30).
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields to ALU controls,
// branch condition, instruction class and legality.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       alu_a_src,
    output logic       alu_b_src,
    output logic [2:0] branch_cond,
    output logic       legal,
    output logic       branch_ok,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal
);

    // Only instr bit 30 carries meaning for the supported instruction set.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_op      = ALU_ADD;
        alu_a_src   = 1'b0;
        alu_b_src   = 1'b0;
        branch_cond = BR_NEVER;
        legal       = 1'b1;
        branch_ok   = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        case (opcode)
            OPC_OP:     alu_op = alu_from_funct(funct3, funct7[5]);
            OPC_OP_IMM: begin
                alu_b_src = 1'b1;
                alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_LOAD: begin
                alu_b_src = 1'b1;
                is_load   = 1'b1;
            end
            OPC_STORE: begin
                alu_b_src = 1'b1;
                is_store  = 1'b1;
            end
            OPC_LUI: begin
                alu_b_src = 1'b1;
                alu_op    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                alu_a_src = 1'b1;
                alu_b_src = 1'b1;
            end
            OPC_JAL:    is_jal = 1'b1;
            OPC_BRANCH: begin
                is_branch = 1'b1;
                branch_ok = 1'b1;
                case (funct3)
                    3'b000:  branch_cond = BR_EQ;
                    3'b001:  branch_cond = BR_NE;
                    3'b100:  branch_cond = BR_LT;
                    3'b101:  branch_cond = BR_GE;
                    3'b110:  branch_cond = BR_LTU;
                    3'b111:  branch_cond = BR_GEU;
                    default: branch_ok   = 1'b0;
                endcase
            end
            OPC_JALR:   legal = 1'b0;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the RV32 datapath: steps each instruction through
// its phases, stretches IO accesses, traps on illegal opcodes or IO timeout.
//
// state        | meaning
// ST_FETCH     | wait for run, latch instruction register
// ST_DECODE    | opcode legality check
// ST_EXECUTE   | ALU operation; branches resolve and retire here
// ST_MEM       | data access, held until IO completes or times out
// ST_WRITEBACK | register write and pc commit
// ST_TRAP      | halted until reset
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int IO_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             is_io,
    input  logic             io_ready,
    output logic             ir_write_en,
    output logic             pc_write_en,
    output logic [2:0]       branch_cond,
    output logic             data_read_en,
    output logic             data_write_en,
    output logic             reg_write_en,
    output logic [1:0]       mem_to_reg,
    output logic             alu_a_src,
    output logic             alu_b_src,
    output logic [3:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int IO_W = $clog2(IO_TIMEOUT + 1);

    state_e          state;
    logic [IO_W-1:0] io_cnt;
    logic            armed;
    logic            mem_done;

    logic [3:0] dec_alu_op;
    logic       dec_a_src;
    logic       dec_b_src;
    logic [2:0] dec_branch_cond;
    logic       dec_legal;
    logic       dec_branch_ok;
    logic       dec_is_load;
    logic       dec_is_store;
    logic       dec_is_branch;
    logic       dec_is_jal;

    ctrl_decode u_decode (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_op      (dec_alu_op),
        .alu_a_src   (dec_a_src),
        .alu_b_src   (dec_b_src),
        .branch_cond (dec_branch_cond),
        .legal       (dec_legal),
        .branch_ok   (dec_branch_ok),
        .is_load     (dec_is_load),
        .is_store    (dec_is_store),
        .is_branch   (dec_is_branch),
        .is_jal      (dec_is_jal)
    );

    assign mem_done = !is_io || io_ready;

    // armed keeps every control quiet for the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            io_cnt      <= '0;
            instr_count <= '0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (pc_write_en)
                instr_count <= instr_count + 1'b1;
            case (state)
                ST_FETCH:
                    if (armed && run)
                        state <= ST_DECODE;
                ST_DECODE:
                    state <= dec_legal ? ST_EXECUTE : ST_TRAP;
                ST_EXECUTE: begin
                    io_cnt <= '0;
                    if (dec_is_branch)
                        state <= dec_branch_ok ? ST_FETCH : ST_TRAP;
                    else if (dec_is_load || dec_is_store)
                        state <= ST_MEM;
                    else
                        state <= ST_WRITEBACK;
                end
                ST_MEM:
                    if (mem_done)
                        state <= dec_is_store ? ST_FETCH : ST_WRITEBACK;
                    else if (io_cnt == IO_W'(IO_TIMEOUT - 1))
                        state <= ST_TRAP;
                    else
                        io_cnt <= io_cnt + 1'b1;
                ST_WRITEBACK:
                    state <= ST_FETCH;
                ST_TRAP:
                    state <= ST_TRAP;
                default:
                    state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_write_en   = 1'b0;
        pc_write_en   = 1'b0;
        branch_cond   = BR_NEVER;
        data_read_en  = 1'b0;
        data_write_en = 1'b0;
        reg_write_en  = 1'b0;
        mem_to_reg    = M2R_ALU;
        alu_a_src     = 1'b0;
        alu_b_src     = 1'b0;
        alu_op        = 4'd0;
        halted        = 1'b0;
        if (armed) begin
            case (state)
                ST_FETCH:
                    ir_write_en = run;
                ST_EXECUTE: begin
                    alu_op    = dec_alu_op;
                    alu_a_src = dec_a_src;
                    alu_b_src = dec_b_src;
                    if (dec_is_branch && dec_branch_ok) begin
                        branch_cond = dec_branch_cond;
                        pc_write_en = 1'b1;
                    end
                end
                ST_MEM: begin
                    alu_op        = dec_alu_op;
                    alu_a_src     = dec_a_src;
                    alu_b_src     = dec_b_src;
                    data_read_en  = dec_is_load;
                    data_write_en = dec_is_store;
                    pc_write_en   = dec_is_store && mem_done;
                end
                ST_WRITEBACK: begin
                    alu_op       = dec_alu_op;
                    alu_a_src    = dec_a_src;
                    alu_b_src    = dec_b_src;
                    reg_write_en = 1'b1;
                    pc_write_en  = 1'b1;
                    mem_to_reg   = dec_is_load ? M2R_MEM : (dec_is_jal ? M2R_PC4 : M2R_ALU);
                    branch_cond  = dec_is_jal ? BR_ALWAYS : BR_NEVER;
                end
                ST_TRAP:
                    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
